fetch_pc_unit: RTL

//  Program-counter and instruction-fetch sequencer for the MIPS core.
//  - Holds the word-addressed PC (30 bit) and fetches each instruction over a req/ack handshake.
//  - Presents the fetched instruction to the datapath.
//  - Computes the next PC when the datapath commits. Branch offsets arrive already

---
 rtl/fetch_pc_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer.
// Holds the word-addressed PC and fetches one instruction per req/ack handshake.
// It presents the instruction to the datapath and advances the PC on commit.
// Handshake: imem_req is high for the whole FETCH state, and imem_addr is held at pc.
// The transfer happens on the rising edge where imem_req and imem_ack are both high.
// commit is honoured only while instr_valid is high.
module fetch_pc_unit #(
   parameter logic [29:0] RESET_PC = 30'h0010_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        commit,
   input  logic        branch_taken,
   input  logic [29:0] branch_off,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jump_reg,
   input  logic [31:0] reg_target,
   output logic [29:0] pc,
   output logic [29:0] pc_plus1,
   output logic        misaligned,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        misaligned_q, misaligned_d;

   logic [29:0] next_pc;
   logic        jr_misaligned;

   // State registers. Reset is synchronous and overrides every other input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         instr_q      <= 32'd0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         misaligned_q <= misaligned_d;
      end
   end

   // Next-PC selection: JR, then J, then taken branch, then sequential.
   // All arithmetic wraps silently at 2^30.
   always_comb begin
      pc_plus1      = pc_q + 30'd1;
      jr_misaligned = jump_reg && (reg_target[1:0] != 2'b00);
      if (jump_reg) begin
         next_pc = reg_target[31:2];
      end else if (jump) begin
         next_pc = {pc_plus1[29:26], jump_target};
      end else if (branch_taken) begin
         next_pc = pc_plus1 + branch_off;
      end else begin
         next_pc = pc_plus1;
      end
   end

   // Sequencer: idle for one cycle, then fetch, execute, and either refetch or halt.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      misaligned_d = misaligned_q;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (commit) begin
               if (jr_misaligned) begin
                  // A misaligned JR leaves pc untouched and parks the unit.
                  misaligned_d = 1'b1;
                  state_d      = HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = FETCH;
               end
            end
         end
         default: begin
            state_d = HALT;
         end
      endcase
   end

   assign imem_req    = (state_q == FETCH);
   assign instr_valid = (state_q == EXEC);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign misaligned  = misaligned_q;
   assign state_dbg   = state_q;

endmodule
